// File: rtl/fp_cvt_arbiter_pkg.sv
// fp_cvt_arbiter_pkg
//   Shared types and constants for the FPU conversion arbiter slice:
//   datapath width, the FPU op encoding and the default request tag width.
//   No ports; imported by fp_convert and fp_cvt_arbiter.
`timescale 1ns/1ps

package fp_cvt_arbiter_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int FPU_OP_W      = 4;
  localparam int FPU_CVT_TAG_W = 6;

  typedef enum logic [FPU_OP_W-1:0] {
    FPU_ADD   = 4'd0,
    FPU_SUB   = 4'd1,
    FPU_MUL   = 4'd2,
    FPU_DIV   = 4'd3,
    FPU_CVTWS = 4'd8,
    FPU_CVTSW = 4'd9
  } fpu_op_t;

endpackage

// File: rtl/fp_convert.sv
// fp_convert
//   Purely combinational single-precision <-> int32 conversion.
//   Ports:
//     op      in   conversion op (fpu_op_t encoding)
//     operand in   DATA_WIDTH source operand
//     result  out  DATA_WIDTH converted value
//   FPU_CVTWS: float -> signed int, truncate toward zero, NaN -> 0x7FFFFFFF,
//              out-of-range values saturate by sign.
//   FPU_CVTSW: signed int -> float, round-to-nearest-even.
//   Any other op yields 0.
`timescale 1ns/1ps

module fp_convert
  import fp_cvt_arbiter_pkg::*;
(
  input  logic [FPU_OP_W-1:0]   op,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0] result
);

  logic        ws_sign;
  logic [7:0]  ws_exp;
  logic [22:0] ws_man;
  logic [31:0] ws_sig;
  logic [31:0] ws_mag;
  logic [31:0] ws_res;

  logic        sw_sign;
  logic [31:0] sw_mag;
  logic [4:0]  sw_msb;
  logic [4:0]  sw_sh;
  logic [7:0]  sw_exp;
  logic [22:0] sw_kept;
  logic        sw_guard;
  logic        sw_sticky;
  logic        sw_up;
  logic [30:0] sw_body;
  logic [31:0] sw_res;

  // Float to int. Exponent 127+k means the value lies in [2^k, 2^(k+1));
  // anything with k >= 31 cannot fit, and saturation by sign also covers
  // the exactly representable -2^31.
  always_comb begin
    ws_sign = operand[31];
    ws_exp  = operand[30:23];
    ws_man  = operand[22:0];
    ws_sig  = {8'd0, 1'b1, ws_man};
    ws_mag  = '0;
    ws_res  = '0;
    if (ws_exp == 8'hFF) begin
      if (ws_man != '0) ws_res = 32'h7FFF_FFFF;
      else              ws_res = ws_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (ws_exp < 8'd127) begin
      ws_res = '0;
    end else if (ws_exp >= 8'd158) begin
      ws_res = ws_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      if (ws_exp >= 8'd150) ws_mag = ws_sig << (ws_exp - 8'd150);
      else                  ws_mag = ws_sig >> (8'd150 - ws_exp);
      ws_res = ws_sign ? (~ws_mag + 32'd1) : ws_mag;
    end
  end

  // Int to float. Magnitudes wider than 24 bits lose low bits; guard is the
  // first dropped bit, sticky the OR of the rest. Adding the round bit to the
  // packed {exp, mantissa} lets a mantissa carry bump the exponent for free.
  always_comb begin
    sw_sign = operand[31];
    sw_mag  = sw_sign ? (~operand + 32'd1) : operand;
    sw_msb  = '0;
    for (int i = 0; i < 32; i++) begin
      if (sw_mag[i]) sw_msb = 5'(i);
    end
    sw_exp    = 8'd127 + {3'd0, sw_msb};
    sw_sh     = '0;
    sw_kept   = '0;
    sw_guard  = 1'b0;
    sw_sticky = 1'b0;
    sw_up     = 1'b0;
    sw_body   = '0;
    sw_res    = '0;
    if (sw_mag == '0) begin
      sw_res = '0;
    end else if (sw_msb <= 5'd23) begin
      sw_kept = 23'(sw_mag << (5'd23 - sw_msb));
      sw_body = {sw_exp, sw_kept};
      sw_res  = {sw_sign, sw_body};
    end else begin
      sw_sh     = sw_msb - 5'd23;
      sw_kept   = 23'(sw_mag >> sw_sh);
      sw_guard  = sw_mag[sw_sh - 5'd1];
      sw_sticky = |(sw_mag & ((32'd1 << (sw_sh - 5'd1)) - 32'd1));
      sw_up     = sw_guard && (sw_sticky || sw_kept[0]);
      sw_body   = {sw_exp, sw_kept} + 31'(sw_up);
      sw_res    = {sw_sign, sw_body};
    end
  end

  always_comb begin
    result = '0;
    case (op)
      FPU_CVTWS: result = ws_res;
      FPU_CVTSW: result = sw_res;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/fp_cvt_arbiter.sv
// fp_cvt_arbiter
//   Shares one fp_convert unit among NUM_REQ requesters with round-robin
//   arbitration and a 2-stage registered pipeline (S1: request, S2: result).
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     req_valid/req_ready    per-requester handshake (ready is one-hot or 0)
//     req_op/operand/tag     flattened per-requester payloads, requester i
//                            at slice [i*W +: W]
//     resp_valid/resp_ready  result handshake
//     resp_data/id/tag       result, issuing requester index and its tag
//     stat_issued/stat_stall accepted-request and backpressure-cycle counters
//   Optional macro FP_CVT_ARB_STATS_EN enables the stat counters; without it
//   both stat ports are constant 0.
`timescale 1ns/1ps

module fp_cvt_arbiter
  import fp_cvt_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int TAG_WIDTH = FPU_CVT_TAG_W,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*FPU_OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [TAG_WIDTH-1:0]          resp_tag,
  output logic [31:0]                   stat_issued,
  output logic [31:0]                   stat_stall
);

  localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  logic [FPU_OP_W-1:0]   op_arr      [NUM_REQ];
  logic [DATA_WIDTH-1:0] operand_arr [NUM_REQ];
  logic [TAG_WIDTH-1:0]  tag_arr     [NUM_REQ];

  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH:0]     idx;
  logic                  found;
  logic                  accept;

  logic                  s1_valid;
  logic [FPU_OP_W-1:0]   s1_op;
  logic [DATA_WIDTH-1:0] s1_operand;
  logic [ID_WIDTH-1:0]   s1_id;
  logic [TAG_WIDTH-1:0]  s1_tag;

  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;
  logic [ID_WIDTH-1:0]   s2_id;
  logic [TAG_WIDTH-1:0]  s2_tag;

  logic [DATA_WIDTH-1:0] cvt_result;
  logic                  s2_adv;
  logic                  s1_free;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i]      = req_op[i*FPU_OP_W +: FPU_OP_W];
      operand_arr[i] = req_operand[i*DATA_WIDTH +: DATA_WIDTH];
      tag_arr[i]     = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
    end
  end

  assign s2_adv  = s1_valid && (!s2_valid || resp_ready);
  assign s1_free = !s1_valid || s2_adv;

  // Search from rr_ptr upward. The sum is one bit wider than an id so the
  // wrap works for NUM_REQ that is not a power of two.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = {1'b0, rr_ptr} + (ID_WIDTH+1)'(off);
      if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
      if (!found && req_valid[idx[ID_WIDTH-1:0]]) begin
        found = 1'b1;
        grant = idx[ID_WIDTH-1:0];
      end
    end
  end

  // Held in reset, nothing may be granted even though S1 looks free.
  assign accept    = rst_n && s1_free && found;
  assign req_ready = accept ? (NUM_REQ'(1) << grant) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant == LAST_ID) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= '0;
      s1_operand <= '0;
      s1_id      <= '0;
      s1_tag     <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_op      <= op_arr[grant];
      s1_operand <= operand_arr[grant];
      s1_id      <= grant;
      s1_tag     <= tag_arr[grant];
    end else if (s2_adv) begin
      s1_valid   <= 1'b0;
    end
  end

  fp_convert u_fp_convert (
    .op      (s1_op),
    .operand (s1_operand),
    .result  (cvt_result)
  );

  // S2 payload only changes on an advance, so it stays stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
      s2_tag   <= '0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      s2_data  <= cvt_result;
      s2_id    <= s1_id;
      s2_tag   <= s1_tag;
    end else if (resp_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign resp_valid = s2_valid;
  assign resp_data  = s2_data;
  assign resp_id    = s2_id;
  assign resp_tag   = s2_tag;

`ifdef FP_CVT_ARB_STATS_EN
  logic [31:0] issued_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (accept)                  issued_cnt <= issued_cnt + 32'd1;
      if (s2_valid && !resp_ready) stall_cnt  <= stall_cnt + 32'd1;
    end
  end

  assign stat_issued = issued_cnt;
  assign stat_stall  = stall_cnt;
`else
  assign stat_issued = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_fp_cvt_arbiter.sv
// tb_fp_cvt_arbiter
//   Directed bench for fp_cvt_arbiter: conversion vectors from a table, then
//   round-robin streaming, backpressure and an asynchronous reset flush.
`timescale 1ns/1ps

module tb_fp_cvt_arbiter;
  import fp_cvt_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int TW = 6;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR*4-1:0]      req_op;
  logic [NR*32-1:0]     req_operand;
  logic [NR*TW-1:0]     req_tag;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_data;
  logic [IW-1:0]        resp_id;
  logic [TW-1:0]        resp_tag;
  logic [31:0]          stat_issued;
  logic [31:0]          stat_stall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          req;
    logic [3:0]  op;
    logic [31:0] operand;
    logic [5:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] expf [NR];
  int          gexp [6];
  int          accepts;

  always #5 clk = ~clk;

  fp_cvt_arbiter #(.NUM_REQ(NR), .TAG_WIDTH(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_operand (req_operand),
    .req_tag     (req_tag),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_id     (resp_id),
    .resp_tag    (resp_tag),
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [3:0] op, input logic [31:0] operand,
                               input logic [5:0] tag);
    req_op[r*4 +: 4]       = op;
    req_operand[r*32 +: 32] = operand;
    req_tag[r*TW +: TW]    = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    req_valid  = '0;
    resp_ready = 1'b1;
    #2 rst_n = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{2, FPU_CVTWS, 32'h40490FDB, 6'd5,  32'h00000003};
    vecs[1]  = '{0, FPU_CVTWS, 32'hC0490FDB, 6'd1,  32'hFFFFFFFD};
    vecs[2]  = '{1, FPU_CVTWS, 32'h7FC00000, 6'd2,  32'h7FFFFFFF};
    vecs[3]  = '{3, FPU_CVTWS, 32'hCF000000, 6'd3,  32'h80000000};
    vecs[4]  = '{0, FPU_CVTWS, 32'h3F000000, 6'd4,  32'h00000000};
    vecs[5]  = '{1, FPU_CVTWS, 32'h7F800000, 6'd6,  32'h7FFFFFFF};
    vecs[6]  = '{2, FPU_CVTWS, 32'h4F000000, 6'd7,  32'h7FFFFFFF};
    vecs[7]  = '{3, FPU_CVTWS, 32'hFF800000, 6'd8,  32'h80000000};
    vecs[8]  = '{0, FPU_CVTWS, 32'h3FC00000, 6'd9,  32'h00000001};
    vecs[9]  = '{1, FPU_CVTWS, 32'hBFC00000, 6'd10, 32'hFFFFFFFF};
    vecs[10] = '{2, FPU_CVTSW, 32'h01000001, 6'd11, 32'h4B800000};
    vecs[11] = '{3, FPU_CVTSW, 32'hFFFFFFFF, 6'd12, 32'hBF800000};
    vecs[12] = '{0, FPU_CVTSW, 32'h00000000, 6'd13, 32'h00000000};
    vecs[13] = '{1, FPU_CVTSW, 32'h80000000, 6'd14, 32'hCF000000};
    vecs[14] = '{2, FPU_CVTSW, 32'h7FFFFFFF, 6'd15, 32'h4F000000};
    vecs[15] = '{3, FPU_ADD,   32'h40490FDB, 6'd63, 32'h00000000};

    expf = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    gexp = '{0, 1, 2, 3, 0, 1};

    rst_n       = 1'b0;
    req_valid   = '0;
    resp_ready  = 1'b1;
    req_op      = '0;
    req_operand = '0;
    req_tag     = '0;

    // Reset state, observed while reset is held.
    #3;
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_data", resp_data, 32'd0);
    checkOutput("rst_resp_id", 32'(resp_id), 32'd0);
    checkOutput("rst_resp_tag", 32'(resp_tag), 32'd0);
    req_valid = 4'hF;
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_stat_issued", stat_issued, 32'd0);
    checkOutput("rst_stat_stall", stat_stall, 32'd0);
    req_valid = '0;
    step();
    #2 rst_n = 1'b1;
    step();

    // Conversion table: single requester, latency of two edges.
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].req, vecs[k].op, vecs[k].operand, vecs[k].tag);
      req_valid = NR'(1) << vecs[k].req;
      #1;
      checkOutput("vec_ready", 32'(req_ready), 32'(NR'(1) << vecs[k].req));
      step();
      req_valid = '0;
      checkOutput("vec_latency", 32'(resp_valid), 32'd0);
      step();
      checkOutput("vec_valid", 32'(resp_valid), 32'd1);
      checkOutput("vec_data", resp_data, vecs[k].exp);
      checkOutput("vec_id", 32'(resp_id), 32'(vecs[k].req));
      checkOutput("vec_tag", 32'(resp_tag), 32'(vecs[k].tag));
    end
    step();
    checkOutput("vec_drained", 32'(resp_valid), 32'd0);

    // Round-robin streaming with every requester valid.
    doReset();
    for (int r = 0; r < NR; r++) applyStimulus(r, FPU_CVTSW, 32'(r + 1), 6'(16 + r));
    for (int i = 0; i < 8; i++) begin
      req_valid = (i < 6) ? 4'hF : 4'h0;
      #1;
      if (i < 6) checkOutput("rr_grant", 32'(req_ready), 32'(NR'(1) << gexp[i]));
      if (i >= 2) begin
        checkOutput("rr_valid", 32'(resp_valid), 32'd1);
        checkOutput("rr_id", 32'(resp_id), 32'(gexp[i-2]));
        checkOutput("rr_data", resp_data, expf[gexp[i-2]]);
        checkOutput("rr_tag", 32'(resp_tag), 32'(16 + gexp[i-2]));
      end
      step();
    end
    req_valid = '0;
    step();
    step();

    // Backpressure: rr_ptr is 2 after the stream above.
    resp_ready = 1'b0;
    accepts    = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 4'hF;
      #1;
      if ((req_valid & req_ready) != '0) accepts++;
      if (i == 0) checkOutput("bp_grant0", 32'(req_ready), 32'h4);
      if (i == 1) checkOutput("bp_grant1", 32'(req_ready), 32'h8);
      if (i >= 2) begin
        checkOutput("bp_ready_low", 32'(req_ready), 32'd0);
        checkOutput("bp_valid", 32'(resp_valid), 32'd1);
        checkOutput("bp_id", 32'(resp_id), 32'd2);
        checkOutput("bp_data", resp_data, expf[2]);
        checkOutput("bp_tag", 32'(resp_tag), 32'd18);
      end
      step();
    end
    checkOutput("bp_accepts", 32'(accepts), 32'd2);
`ifdef FP_CVT_ARB_STATS_EN
    checkOutput("stat_issued", stat_issued, 32'd8);
    checkOutput("stat_stall", stat_stall, 32'd6);
`else
    checkOutput("stat_issued_off", stat_issued, 32'd0);
    checkOutput("stat_stall_off", stat_stall, 32'd0);
`endif

    // Release: drain in order, no duplicates.
    req_valid  = '0;
    resp_ready = 1'b1;
    #1;
    checkOutput("drain0_valid", 32'(resp_valid), 32'd1);
    checkOutput("drain0_id", 32'(resp_id), 32'd2);
    step();
    checkOutput("drain1_valid", 32'(resp_valid), 32'd1);
    checkOutput("drain1_id", 32'(resp_id), 32'd3);
    checkOutput("drain1_data", resp_data, expf[3]);
    step();
    checkOutput("drain_empty0", 32'(resp_valid), 32'd0);
    step();
    checkOutput("drain_empty1", 32'(resp_valid), 32'd0);

    // Fill both stages (grants 0 then 1), then reset asynchronously.
    resp_ready = 1'b0;
    req_valid  = 4'hF;
    step();
    step();
    checkOutput("full_before_reset", 32'(resp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("async_req_ready", 32'(req_ready), 32'd0);
    req_valid  = '0;
    resp_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("post_reset_quiet", 32'(resp_valid), 32'd0);
    end
    req_valid = 4'hF;
    #1;
    checkOutput("post_reset_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_cvt_arbiter.md
Name: fp_cvt_arbiter

Overview:
- Shares one fp_convert datapath (FCVTWS / FCVTSW) among NUM_REQ requesters, for example per-lane issue slots of the FPU.
- Arbitration is round-robin with a valid/ready request handshake.
- The shared unit is wrapped in a 2-stage registered pipeline. Full throughput is 1 conversion per cycle.
- Each response returns the originating requester id and tag to the writeback/scoreboard path.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- TAG_WIDTH, 6, opaque tag carried with each request and returned with its response.
- ID_WIDTH, $clog2(NUM_REQ), width of the requester id (localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  in  NUM_REQ x fpu_op_t  conversion op per requester.
- req_operand  in  NUM_REQ x DATA_WIDTH  source operand.
- req_tag  in  NUM_REQ x TAG_WIDTH  request tag.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accept.
- resp_data  out  DATA_WIDTH  conversion result.
- resp_id  out  ID_WIDTH  index of the requester that issued this result.
- resp_tag  out  TAG_WIDTH  tag of the issuing request.
- stat_issued  out  32  accepted-request count (optional feature).
- stat_stall  out  32  backpressure cycle count (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - s1_valid = s2_valid = 0; resp_valid = 0; resp_data / resp_id / resp_tag = 0.
  - rr_ptr = 0; req_ready = 0; stat counters = 0.
- Pipeline:
  - S1 register holds {op, operand, id, tag}.
  - The combinational fp_convert operates on S1.
  - S2 register holds {result, id, tag} and drives resp_* directly.
- Advance conditions:
  - s2_adv = s1_valid && (!s2_valid || resp_ready).
  - s1_free = !s1_valid || s2_adv.
- Arbitration:
  - Grant only when s1_free.
  - Grant the first asserted req_valid searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[g] = 1 for the granted index only.
  - Handshake completes when req_valid[g] && req_ready[g] in the same cycle. req_ready may depend combinationally on req_valid. Requesters must hold their payload until accepted.
- rr_ptr update:
  - On accept, rr_ptr <= (g+1) mod NUM_REQ, with explicit wrap for non-power-of-2 NUM_REQ.
  - With no accept, rr_ptr is unchanged.
- Latency: accept in cycle N, resp_valid asserts at N+2 if not stalled.
- Output stage:
  - resp_valid falls only when resp_ready=1 and nothing advances into S2.
  - While resp_valid && !resp_ready, resp_data / resp_id / resp_tag are held stable.
- Backpressure: with resp_ready held low, at most 2 requests are in flight. After both stages fill, all req_ready = 0.
- Simultaneous events: S2 dequeue, S1→S2 advance and a new accept may all occur in one cycle, giving no bubble.
- Op handling:
  - FPU_CVTWS / FPU_CVTSW follow the unit's semantics: truncation; NaN → 0x7FFFFFFF; saturation; round-to-nearest-even.
  - Any other op value is still accepted and produces resp_data = 0.
- Reset mid-operation flushes both stages. In-flight requests are lost and no response is emitted.

Optional Feature:
- Macro: FP_CVT_ARB_STATS_EN.
- When defined:
  - stat_issued increments on every accepted request.
  - stat_stall increments each cycle resp_valid && !resp_ready.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- When undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- pkg_opengpu already supplies DATA_WIDTH, fpu_op_t, FPU_CVTWS and FPU_CVTSW.
- Add FPU_CVT_TAG_W (default 6) to the package.
- Sub-module: fp_convert, instantiated once between S1 and S2.
- The round-robin grant logic stays inline.

Test Plan:
- Requester 2, CVTWS 0x40490FDB, tag 5 → 2 cycles later: resp_data=0x00000003, resp_id=2, resp_tag=5.
- CVTWS inputs:
  - 0xC0490FDB → 0xFFFFFFFD.
  - 0x7FC00000 → 0x7FFFFFFF.
  - 0xCF000000 → 0x80000000.
  - 0x3F000000 → 0x00000000.
- CVTSW inputs:
  - 0x01000001 → 0x4B800000 (tie to even).
  - 0xFFFFFFFF → 0xBF800000.
  - 0x00000000 → 0x00000000.
- All 4 requesters valid continuously, resp_ready=1 → grants 0,1,2,3,0,1 on consecutive cycles; resp_id sequence matches with no bubbles.
- resp_ready=0 for 6 cycles with all valid:
  - Exactly 2 accepts, then req_ready=0.
  - resp_* stable throughout.
  - Releasing resp_ready drains in order with no loss or duplication.
  - stat_stall=6 when the macro is enabled.
- rst_n pulsed low asynchronously with both stages full → resp_valid drops immediately; no response after release; next grant goes to requester 0.
